// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Sequencer and lock supervisor for the display PLL. It pulses the PLL's
// active-high reset and watches the asynchronous `locked` output. The
// downstream system reset is released only after lock has been stable for
// LOCK_STABLE_CYC cycles. On lock loss the PLL is reset again. A lock timeout
// causes a retry. After MAX_RETRIES+1 failed attempts the block parks in FAULT.
//
// Ports:
//   refclk     in   free-running reference clock (only clock)
//   rst_n      in   asynchronous active-low reset
//   pll_locked in   PLL locked flag, asynchronous to refclk
//   restart    in   one-cycle synchronous request to restart the sequence
//   pll_rst    out  active-high PLL reset (registered)
//   sys_rst_n  out  active-low downstream reset (registered, refclk domain)
//   lock_lost  out  one-cycle pulse when lock drops while in RUN
//   fault      out  high while in FAULT
//   retry_cnt  out  failed attempts in the current sequence
//   loss_cnt   out  lock losses since reset, saturating at 255
//   state      out  RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRIES      = 7,
  parameter int CNT_W            = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       lock_lost,
  output logic       fault,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Terminal counts for the shared counter.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

  state_t           cur_state;
  state_t           next_state;
  logic             sync_ff;
  logic             locked_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic [7:0]       next_retry;
  logic [7:0]       next_loss;
  logic             next_lock_lost;

  assign state = cur_state;

  // Two-flop synchronizer bringing pll_locked into the refclk domain.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_ff  <= pll_locked;
      locked_s <= sync_ff;
    end
  end

  // State, counters and outputs. Outputs are decoded from next_state so that
  // they change on the same edge as the state transition.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= RESET_PLL;
      cnt       <= CNT_ZERO;
      retry_cnt <= 8'd0;
      loss_cnt  <= 8'd0;
      lock_lost <= 1'b0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cur_state <= next_state;
      cnt       <= next_cnt;
      retry_cnt <= next_retry;
      loss_cnt  <= next_loss;
      lock_lost <= next_lock_lost;
      pll_rst   <= (next_state == RESET_PLL) || (next_state == FAULT);
      sys_rst_n <= (next_state == RUN);
      fault     <= (next_state == FAULT);
    end
  end

  // Next-state logic; restart overrides every state, including a lock drop
  // detected in RUN on the same edge.
  always_comb begin
    next_state     = cur_state;
    next_cnt       = cnt;
    next_retry     = retry_cnt;
    next_loss      = loss_cnt;
    next_lock_lost = 1'b0;

    if (restart) begin
      next_state = RESET_PLL;
      next_cnt   = CNT_ZERO;
      next_retry = 8'd0;
    end else begin
      case (cur_state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            next_state = WAIT_LOCK;
            next_cnt   = CNT_ZERO;
          end else begin
            next_cnt = cnt + CNT_ONE;
          end
        end

        WAIT_LOCK: begin
          if (locked_s) begin
            next_state = STABILIZE;
            next_cnt   = CNT_ZERO;
          end else if (cnt == TIMEOUT_LAST) begin
            next_cnt = CNT_ZERO;
            if (retry_cnt == RETRY_LIMIT) begin
              next_state = FAULT;
            end else begin
              next_state = RESET_PLL;
              next_retry = retry_cnt + 8'd1;
            end
          end else begin
            next_cnt = cnt + CNT_ONE;
          end
        end

        STABILIZE: begin
          // A glitch in lock restarts the wait with a fresh timeout but does
          // not count as a failed attempt.
          if (!locked_s) begin
            next_state = WAIT_LOCK;
            next_cnt   = CNT_ZERO;
          end else if (cnt == STABLE_LAST) begin
            next_state = RUN;
            next_cnt   = CNT_ZERO;
            next_retry = 8'd0;
          end else begin
            next_cnt = cnt + CNT_ONE;
          end
        end

        RUN: begin
          if (!locked_s) begin
            next_state     = RESET_PLL;
            next_cnt       = CNT_ZERO;
            next_lock_lost = 1'b1;
            if (loss_cnt != 8'hFF) begin
              next_loss = loss_cnt + 8'd1;
            end else begin
              next_loss = loss_cnt;
            end
          end else begin
            next_cnt = cnt;
          end
        end

        FAULT: begin
          next_state = FAULT;
          next_cnt   = CNT_ZERO;
        end

        default: begin
          next_state = RESET_PLL;
          next_cnt   = CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed, self-checking bench for pll_reset_sequencer with small timing
// parameters (pulse 4, timeout 10, stable 8, 2 retries). Each scenario task
// drives stimulus and compares outputs against hand-computed values, sampled
// 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_lost;
  logic       fault;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .RST_PULSE_CYC   (4),
    .LOCK_TIMEOUT_CYC(10),
    .LOCK_STABLE_CYC (8),
    .MAX_RETRIES     (2),
    .CNT_W           (16)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .lock_lost (lock_lost),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state     (state)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b1; restart = 1'b0;
    #8;
    checks++; if (state !== 3'd0)     begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (pll_rst !== 1'b1)   begin errors++; $display("FAIL reset_pll_rst got %b exp 1", pll_rst); end
    checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n got %b exp 0", sys_rst_n); end
    checks++; if ({lock_lost, fault} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {lock_lost, fault}); end
    checks++; if ({retry_cnt, loss_cnt} !== 16'h0000) begin errors++; $display("FAIL reset_counts got %h exp 0000", {retry_cnt, loss_cnt}); end
    #4 rst_n = 1'b1;  // released mid-cycle; next rising edge is edge 1
  endtask

  task automatic test_lock_sequence();
    tick(3);  // edge 3
    checks++; if (pll_rst !== 1'b1 || state !== 3'd0) begin errors++; $display("FAIL seq_edge3 got rst=%b st=%0d exp rst=1 st=0", pll_rst, state); end
    tick(1);  // edge 4
    checks++; if (pll_rst !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL seq_edge4 got rst=%b st=%0d exp rst=0 st=1", pll_rst, state); end
    tick(1);  // edge 5
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL seq_edge5 got st=%0d exp 2", state); end
    tick(7);  // edge 12
    checks++; if (state !== 3'd2 || sys_rst_n !== 1'b0) begin errors++; $display("FAIL seq_edge12 got st=%0d srst=%b exp st=2 srst=0", state, sys_rst_n); end
    tick(1);  // edge 13
    checks++; if (state !== 3'd3 || sys_rst_n !== 1'b1 || retry_cnt !== 8'd0) begin errors++; $display("FAIL seq_edge13 got st=%0d srst=%b rc=%0d exp st=3 srst=1 rc=0", state, sys_rst_n, retry_cnt); end
  endtask

  task automatic test_stabilize_drop();
    restart = 1'b1; tick(1); restart = 1'b0;  // edge R
    checks++; if (state !== 3'd0 || sys_rst_n !== 1'b0) begin errors++; $display("FAIL stab_restart got st=%0d srst=%b exp st=0 srst=0", state, sys_rst_n); end
    tick(8);  // R+8, stabilize counter 3; drop lands on locked_s at counter 5
    pll_locked = 1'b0;
    tick(3);  // R+11
    checks++; if (state !== 3'd1 || sys_rst_n !== 1'b0) begin errors++; $display("FAIL stab_drop got st=%0d srst=%b exp st=1 srst=0", state, sys_rst_n); end
    pll_locked = 1'b1;
    tick(3);  // R+14
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL stab_relock got st=%0d exp 2", state); end
    tick(7);  // R+21
    checks++; if (state !== 3'd2 || sys_rst_n !== 1'b0) begin errors++; $display("FAIL stab_full_wait got st=%0d srst=%b exp st=2 srst=0", state, sys_rst_n); end
    tick(1);  // R+22
    checks++; if (state !== 3'd3 || sys_rst_n !== 1'b1) begin errors++; $display("FAIL stab_release got st=%0d srst=%b exp st=3 srst=1", state, sys_rst_n); end
  endtask

  task automatic test_run_loss();
    pll_locked = 1'b0;
    tick(2);  // E+2, not yet seen
    checks++; if (state !== 3'd3 || sys_rst_n !== 1'b1 || lock_lost !== 1'b0) begin errors++; $display("FAIL loss_early got st=%0d srst=%b ll=%b exp 3/1/0", state, sys_rst_n, lock_lost); end
    tick(1);  // E+3
    checks++; if (state !== 3'd0 || sys_rst_n !== 1'b0 || pll_rst !== 1'b1) begin errors++; $display("FAIL loss_detect got st=%0d srst=%b prst=%b exp 0/0/1", state, sys_rst_n, pll_rst); end
    checks++; if (lock_lost !== 1'b1 || loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_pulse got ll=%b lc=%0d exp ll=1 lc=1", lock_lost, loss_cnt); end
    pll_locked = 1'b1;
    tick(1);
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL loss_pulse_width got ll=%b exp 0", lock_lost); end
    tick(11);  // E+15
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL loss_rerun_stab got st=%0d exp 2", state); end
    tick(1);   // E+16
    checks++; if (state !== 3'd3 || sys_rst_n !== 1'b1) begin errors++; $display("FAIL loss_rerun_run got st=%0d srst=%b exp 3/1", state, sys_rst_n); end
  endtask

  task automatic test_restart_collision();
    pll_locked = 1'b0;
    tick(2);
    restart = 1'b1;
    tick(1);  // edge where the drop is detected
    restart = 1'b0;
    checks++; if (state !== 3'd0 || lock_lost !== 1'b0 || loss_cnt !== 8'd1) begin errors++; $display("FAIL collide got st=%0d ll=%b lc=%0d exp 0/0/1", state, lock_lost, loss_cnt); end
    pll_locked = 1'b1;
    tick(1);
    checks++; if (lock_lost !== 1'b0 || loss_cnt !== 8'd1) begin errors++; $display("FAIL collide_after got ll=%b lc=%0d exp 0/1", lock_lost, loss_cnt); end
    tick(12);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL collide_rerun got st=%0d exp 3", state); end
  endtask

  task automatic test_loss_saturation();
    for (int i = 0; i < 255; i++) begin
      pll_locked = 1'b0;
      tick(3);
      pll_locked = 1'b1;
      tick(13);
      if (i == 253) begin
        checks++; if (loss_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", loss_cnt); end
      end
    end
    checks++; if (loss_cnt !== 8'd255 || state !== 3'd3) begin errors++; $display("FAIL sat_256 got lc=%0d st=%0d exp 255/3", loss_cnt, state); end
  endtask

  task automatic test_retry_fault();
    pll_locked = 1'b0; restart = 1'b1;
    tick(1);  // edge R
    restart = 1'b0;
    checks++; if (state !== 3'd0 || pll_rst !== 1'b1 || retry_cnt !== 8'd0) begin errors++; $display("FAIL retry_start got st=%0d prst=%b rc=%0d exp 0/1/0", state, pll_rst, retry_cnt); end
    tick(3);  // R+3
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL retry_pulse1 got %b exp 1", pll_rst); end
    tick(1);  // R+4
    checks++; if (pll_rst !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL retry_wait1 got prst=%b st=%0d exp 0/1", pll_rst, state); end
    tick(9);  // R+13
    checks++; if (state !== 3'd1 || retry_cnt !== 8'd0) begin errors++; $display("FAIL retry_pre_to got st=%0d rc=%0d exp 1/0", state, retry_cnt); end
    tick(1);  // R+14
    checks++; if (state !== 3'd0 || retry_cnt !== 8'd1 || pll_rst !== 1'b1) begin errors++; $display("FAIL retry_1 got st=%0d rc=%0d prst=%b exp 0/1/1", state, retry_cnt, pll_rst); end
    tick(14); // R+28
    checks++; if (state !== 3'd0 || retry_cnt !== 8'd2) begin errors++; $display("FAIL retry_2 got st=%0d rc=%0d exp 0/2", state, retry_cnt); end
    tick(13); // R+41
    checks++; if (state !== 3'd1 || fault !== 1'b0) begin errors++; $display("FAIL retry_3_wait got st=%0d flt=%b exp 1/0", state, fault); end
    tick(1);  // R+42
    checks++; if (state !== 3'd4 || fault !== 1'b1 || pll_rst !== 1'b1 || retry_cnt !== 8'd2) begin errors++; $display("FAIL fault_entry got st=%0d flt=%b prst=%b rc=%0d exp 4/1/1/2", state, fault, pll_rst, retry_cnt); end
    tick(5);
    checks++; if (state !== 3'd4 || sys_rst_n !== 1'b0) begin errors++; $display("FAIL fault_hold got st=%0d srst=%b exp 4/0", state, sys_rst_n); end
    restart = 1'b1; tick(1); restart = 1'b0;
    checks++; if (state !== 3'd0 || fault !== 1'b0 || retry_cnt !== 8'd0 || pll_rst !== 1'b1) begin errors++; $display("FAIL fault_restart got st=%0d flt=%b rc=%0d prst=%b exp 0/0/0/1", state, fault, retry_cnt, pll_rst); end
  endtask

  task automatic test_async_reset();
    pll_locked = 1'b1; restart = 1'b1;
    tick(1); restart = 1'b0;  // edge R
    tick(7);                  // R+7, in STABILIZE
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL async_pre got st=%0d exp 2", state); end
    #2 rst_n = 1'b0;
    #1;  // well before the next rising edge
    checks++; if (state !== 3'd0 || pll_rst !== 1'b1 || sys_rst_n !== 1'b0) begin errors++; $display("FAIL async_rst got st=%0d prst=%b srst=%b exp 0/1/0", state, pll_rst, sys_rst_n); end
    checks++; if (lock_lost !== 1'b0 || fault !== 1'b0 || retry_cnt !== 8'd0 || loss_cnt !== 8'd0) begin errors++; $display("FAIL async_rst_cnt got ll=%b flt=%b rc=%0d lc=%0d exp 0/0/0/0", lock_lost, fault, retry_cnt, loss_cnt); end
    #2 rst_n = 1'b1;
    tick(2);
    checks++; if (state !== 3'd0 || pll_rst !== 1'b1) begin errors++; $display("FAIL async_after got st=%0d prst=%b exp 0/1", state, pll_rst); end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_stabilize_drop();
    test_run_loss();
    test_restart_collision();
    test_loss_saturation();
    test_retry_fault();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
